// File: rtl/i2so_pkg.sv
// Shared constants and FSM encoding for the I2S output transmitter.
package i2so_pkg;

  localparam int I2SO_DATA_WIDTH = 16;
  localparam int I2SO_CLK_DIV    = 4;
  localparam int UNDERRUN_CNT_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/i2so_clkgen.sv
// SCK generator: divides clk by 2*CLK_DIV and flags the edges where SCK toggles.
module i2so_clkgen
  import i2so_pkg::*;
#(
  parameter int CLK_DIV = I2SO_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes mark the clk edge on which SCK will change, so the shifter can update in step.
  assign wrap     = run && (div_cnt == DIV_LAST);
  assign rise_stb = wrap && !sck;
  assign fall_stb = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2so_tx.sv
// I2S output transmitter: holding register, L/R word shifter and FSM on top of i2so_clkgen.
// Optional underrun counter port enabled by defining I2SO_UNDERRUN_CNT_EN.
module i2so_tx
  import i2so_pkg::*;
#(
  parameter int DATA_WIDTH = I2SO_DATA_WIDTH,
  parameter int CLK_DIV    = I2SO_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2so_en,
  input  logic [DATA_WIDTH-1:0] i2so_inp_data,
  input  logic                  i2so_inp_rts,
  output logic                  i2so_inp_rtr,
  output logic                  i2so_sck,
  output logic                  i2so_ws,
  output logic                  i2so_sd
`ifdef I2SO_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] i2so_underrun_cnt
`endif
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_PRE  = BIT_W'(DATA_WIDTH - 2);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  run;
  logic                  start;
  logic                  load;
  logic                  shift;
  logic                  drop;
  logic                  accept;
  logic                  rise_stb;
  logic                  fall_stb;

  assign run          = (state == ST_RUN) && i2so_en;
  assign drop         = (state == ST_RUN) && !i2so_en;
  assign accept       = i2so_inp_rts && !hold_vld;
  assign i2so_inp_rtr = !hold_vld;

  i2so_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sck      (i2so_sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i2so_en && hold_vld) state_nxt = ST_RUN;
      ST_RUN:  if (!i2so_en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Load slots are the IDLE->RUN cycle and the fall after each LSB; other falls shift.
  always_comb begin
    start = 1'b0;
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      ST_IDLE: start = i2so_en && hold_vld;
      ST_RUN: begin
        load  = i2so_en && fall_stb && (bit_cnt == BIT_LAST);
        shift = i2so_en && fall_stb && (bit_cnt != BIT_LAST);
      end
      default: ;
    endcase
  end

  // A word accepted on a load-slot edge waits for the next slot; the slot itself underruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (drop) begin
      hold_vld <= 1'b0;
    end else if (accept) begin
      hold     <= i2so_inp_data;
      hold_vld <= 1'b1;
    end else if ((start || load) && hold_vld) begin
      hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      i2so_sd <= 1'b0;
      i2so_ws <= 1'b0;
    end else if (!run && !start) begin
      shreg   <= '0;
      bit_cnt <= '0;
      i2so_sd <= 1'b0;
      i2so_ws <= 1'b0;
    end else if (start || load) begin
      shreg   <= hold_vld ? hold : '0;
      i2so_sd <= hold_vld & hold[DATA_WIDTH-1];
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= shreg << 1;
      i2so_sd <= shreg[DATA_WIDTH-2];
      bit_cnt <= bit_cnt + BIT_W'(1);
      if (bit_cnt == BIT_PRE) i2so_ws <= !i2so_ws;
    end
  end

`ifdef I2SO_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2so_underrun_cnt <= '0;
    end else if (load && !hold_vld && (i2so_underrun_cnt != '1)) begin
      i2so_underrun_cnt <= i2so_underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end
`endif

  // SD must never change on the edge the receiver samples it.
  a_no_update_on_rise: assert property (@(posedge clk) disable iff (!rst_n)
    !(rise_stb && (load || shift)));

endmodule

// File: doc/i2so_tx.md
# i2so_tx

I2S output transmitter: the transmit-direction counterpart of the I2S input path's receive FIFO. Accepts parallel audio words from an upstream FIFO over the team's rts/rtr handshake, alternating left/right. Generates SCK and WS as bus master and shifts each word MSB-first onto SD in standard I2S format. Sits between the output FIFO and the chip pads.

## Interface
- `DATA_WIDTH`, 16: bits per channel word; legal range 8..32.
- `CLK_DIV`, 4: `clk` cycles per SCK half-period; must be ≥2.
- `clk` in 1: system clock, all logic on its rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `i2so_en` in 1: transmit enable.
- `i2so_inp_data` in DATA_WIDTH: word from the upstream FIFO.
- `i2so_inp_rts` in 1: upstream has a word ready to send.
- `i2so_inp_rtr` out 1: block is ready to receive a word.
- `i2so_sck` out 1: I2S bit clock.
- `i2so_ws` out 1: word select; 0 = left, 1 = right.
- `i2so_sd` out 1: serial data.
- `i2so_underrun_cnt` out 8: present only with `I2SO_UNDERRUN_CNT_EN`.

## Operation
- One-entry holding register (`hold`, `hold_vld`). `i2so_inp_rtr = !hold_vld`. The block accepts a word on a `clk` edge when `rts && rtr`, and sets `hold_vld`.
- Words alternate L, R, L, … The first word accepted after reset or after disable is left.
- FSM states:
  - IDLE: `sck`, `ws`, `sd` held at 0; divider and bit counter at 0. Accepting into `hold` is allowed. The FSM goes to RUN when `i2so_en && hold_vld`.
  - RUN: divider runs and SCK toggles.
- Divider `div_cnt` counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and SCK toggles. A 0→1 toggle is a rise strobe; a 1→0 toggle is a fall strobe.
- All `sd`/`ws` updates happen only at fall strobes, and on the IDLE→RUN transition cycle. The receiver samples on SCK rise.
- Load slot: the IDLE→RUN cycle, and every fall strobe with `bit_cnt == DATA_WIDTH-1`.
  - Shift register ← `hold` (`hold_vld` cleared) if `hold_vld`, else all-zeros (underrun).
  - `sd` ← MSB; `bit_cnt` ← 0.
- Other fall strobes: shift left, `sd` ← next bit, `bit_cnt`++.
- WS toggles on the fall strobe that drives the LSB (`bit_cnt` becomes DATA_WIDTH-1). WS therefore leads the next channel's MSB by one SCK (standard I2S).
- Underrun: the slot transmits zeros and the L/R order still advances. The next accepted word goes to the following channel.
- Simultaneous accept and load slot in the same cycle: the load uses the registered `hold_vld` only. If `hold` was empty, the slot underruns and the new word lands in `hold` for the next slot.
- `i2so_en` deasserted in RUN: on the next edge return to IDLE. SCK/WS/SD go to 0, counters clear, and `hold_vld` clears (the word is discarded). Channel order resets to left.

## Timing
- Reset values: `sck`=0, `ws`=0, `sd`=0, `i2so_inp_rtr`=1, `hold_vld`=0, FSM=IDLE, counters 0, `i2so_underrun_cnt`=0.
- SCK period = 2·CLK_DIV `clk` cycles. Frame = 2·DATA_WIDTH SCK periods.
- First MSB is on `sd` in the cycle after IDLE→RUN. First SCK rise comes CLK_DIV cycles later.
- `rtr` reasserts the cycle after a load slot consumes `hold`. Upstream has ≥ DATA_WIDTH·2·CLK_DIV−1 cycles to refill before the next slot.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `I2SO_UNDERRUN_CNT_EN` defined: `i2so_underrun_cnt` port exists. It increments by 1 per underrun slot and saturates at 255. It clears only on reset.
- Not defined: port and counter are absent. Underrun still transmits zeros.

## Structure
- `i2so_pkg`: FSM state encoding (IDLE, RUN), default DATA_WIDTH/CLK_DIV constants, and underrun counter width (8).
- Sub-module `i2so_clkgen`:
  - contains the divider and SCK register;
  - outputs `sck`, `rise_stb`, `fall_stb`;
  - input `run` clears it when low.
- The top level holds the FSM, the holding register and the shifter.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN → asynchronously `sck`/`ws`/`sd`=0 and `rtr`=1. After release, no SCK until enabled.
- Single frame (DATA_WIDTH=16, CLK_DIV=2): push L=0xA5A5, R=0x5A5A, `en`=1 → sampling `sd` on SCK rises yields 0xA5A5 with `ws`=0, then 0x5A5A with `ws`=1. `ws` flips with each LSB. SCK period = 4 cycles.
- Back-pressure: hold `rts`=1 with a continuous ramp 0x0001, 0x0002, … → `rtr` is low except one cycle per slot. No word is dropped or duplicated across 8 frames.
- Underrun: supply L only, then stall → R slot transmits 0x0000 and `i2so_underrun_cnt`=1. The next pushed word goes out as L. 300 underruns → counter=255.
- Disable mid-word: drop `en` at bit 5 of L → next cycle IDLE, outputs 0, `rtr`=1. Re-enable with 0x1234 → it is transmitted as left from its MSB.
- Same-cycle accept at a load slot with `hold` empty → that slot sends zeros. The accepted word is sent in the following slot.
